// File: rtl/noc_packet_tx.sv
// noc_packet_tx: network-interface transmitter for a wormhole router input port.
// It takes a packet descriptor and a stream of payload words, and sends them as
// HEADER / BODY / TAIL flits on the enable/ack handshake. It also counts the flits
// and packets that the router accepts.
module noc_packet_tx #(
  parameter int ADDR_W     = 4,
  parameter int PAYLOAD_W  = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16,
  parameter int SRC_X      = 1,
  parameter int SRC_Y      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [ADDR_W-1:0]    pkt_dst_x_i,
  input  logic [ADDR_W-1:0]    pkt_dst_y_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic                 enable_o,
  output logic [1:0]           flit_type_o,
  output logic [PAYLOAD_W-1:0] flit_payload_o,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     flits_sent_o,
  output logic [CNT_W-1:0]     pkts_sent_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] TYPE_HEADER = 2'd0;
  localparam logic [1:0] TYPE_BODY   = 2'd1;
  localparam logic [1:0] TYPE_TAIL   = 2'd2;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_HDR        = 2'd1;
  localparam logic [1:0] S_DATA       = 2'd2;
  localparam logic [1:0] S_EMPTY_TAIL = 2'd3;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]           state;
  logic [ADDR_W-1:0]    dst_x;
  logic [ADDR_W-1:0]    dst_y;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     rem;

  logic [PAYLOAD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 empty;
  logic [PAYLOAD_W-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 transfer;
  logic                 tail_flit;
  logic [PAYLOAD_W-1:0] header_word;

  // The pointers carry one extra wrap bit, so a full FIFO and an empty FIFO
  // give different counts.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign data_ready_o = !full;
  assign push         = data_valid_i && !full;
  assign transfer     = enable_o && ack_i;
  assign pop          = transfer && (state == S_DATA);
  assign tail_flit    = ((state == S_DATA) && (rem == LEN_ONE)) || (state == S_EMPTY_TAIL);
  assign pkt_ready_o  = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);

  // Header word: destination, then source, with the unused upper bits cleared.
  always_comb begin
    header_word                     = '0;
    header_word[ADDR_W-1:0]         = dst_x;
    header_word[2*ADDR_W-1:ADDR_W]  = dst_y;
    header_word[3*ADDR_W-1:2*ADDR_W] = ADDR_W'(SRC_X);
    header_word[4*ADDR_W-1:3*ADDR_W] = ADDR_W'(SRC_Y);
  end

  // Flit outputs depend only on registered state and the FIFO head. This keeps
  // them stable while the router stalls.
  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    enable_o       = 1'b0;
    flit_type_o    = TYPE_BODY;
    flit_payload_o = '0;
    case (state)
      S_HDR: begin
        enable_o       = 1'b1;
        flit_type_o    = TYPE_HEADER;
        flit_payload_o = header_word;
      end
      S_DATA: begin
        if (!empty) begin
          enable_o       = 1'b1;
          flit_type_o    = (rem == LEN_ONE) ? TYPE_TAIL : TYPE_BODY;
          flit_payload_o = head;
        end
      end
      S_EMPTY_TAIL: begin
        enable_o    = 1'b1;
        flit_type_o = TYPE_TAIL;
      end
      default: ;
    endcase
  end

  // Packet sequencing: accept a descriptor, send the header, then stream the payload.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      dst_x <= '0;
      dst_y <= '0;
      len   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_valid_i) begin
            dst_x <= pkt_dst_x_i;
            dst_y <= pkt_dst_y_i;
            len   <= pkt_len_i;
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (ack_i) begin
            rem   <= len;
            state <= (len != '0) ? S_DATA : S_EMPTY_TAIL;
          end
        end
        S_DATA: begin
          if (pop) begin
            rem <= rem - LEN_ONE;
            if (rem == LEN_ONE) state <= S_IDLE;
          end
        end
        S_EMPTY_TAIL: begin
          if (ack_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers. Reset flushes any buffered payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    if (push) mem[wr_ptr[PTR_W-1:0]] <= data_i;
  end

  // Statistics: every accepted flit, and every accepted tail. Both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flits_sent_o <= '0;
      pkts_sent_o  <= '0;
    end else if (transfer) begin
      flits_sent_o <= flits_sent_o + 1'b1;
      if (tail_flit) pkts_sent_o <= pkts_sent_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_packet_tx.sv
// Testbench for noc_packet_tx. The reference model is a list of expected flits:
// each accepted descriptor appends its header, then one entry per payload word
// (or an empty tail). Payload words are matched in the order they entered the FIFO.
module tb_noc_packet_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [3:0]  pkt_dst_x_i;
  logic [3:0]  pkt_dst_y_i;
  logic [7:0]  pkt_len_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] data_i;
  logic        enable_o;
  logic [1:0]  flit_type_o;
  logic [31:0] flit_payload_o;
  logic        ack_i;
  logic        busy_o;
  logic [15:0] flits_sent_o;
  logic [15:0] pkts_sent_o;

  noc_packet_tx dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_dst_x_i(pkt_dst_x_i), .pkt_dst_y_i(pkt_dst_y_i), .pkt_len_i(pkt_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .enable_o(enable_o), .flit_type_o(flit_type_o), .flit_payload_o(flit_payload_o),
    .ack_i(ack_i), .busy_o(busy_o),
    .flits_sent_o(flits_sent_o), .pkts_sent_o(pkts_sent_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ftype;
    logic        is_data;
    logic [31:0] payload;
  } flit_t;

  flit_t       exp_q[$];
  logic [31:0] data_q[$];
  int          n_flits = 0;
  int          n_pkts  = 0;
  int          n_desc  = 0;
  int          checks  = 0;
  int          passed  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: check the outputs at the falling edge, update the model for the
  // coming rising edge, then return 1 ns after that edge.
  task automatic cycle();
    logic  exp_en;
    logic  can_push;
    logic  idle;
    flit_t f;
    logic [31:0] exp_pl;
    @(negedge clk);
    idle     = (exp_q.size() == 0);
    can_push = (data_q.size() < DEPTH);
    exp_en   = !idle && (!exp_q[0].is_data || data_q.size() != 0);
    chk("pkt_ready", pkt_ready_o, idle);
    chk("busy", busy_o, !idle);
    chk("data_ready", data_ready_o, can_push);
    chk("flits_sent", flits_sent_o, 32'(16'(n_flits)));
    chk("pkts_sent", pkts_sent_o, 32'(16'(n_pkts)));
    chk("enable", enable_o, exp_en);
    if (exp_en) begin
      f      = exp_q[0];
      exp_pl = f.is_data ? data_q[0] : f.payload;
      chk("flit_type", flit_type_o, f.ftype);
      chk("flit_payload", flit_payload_o, exp_pl);
      if (ack_i) begin
        if (f.is_data) void'(data_q.pop_front());
        void'(exp_q.pop_front());
        n_flits++;
        if (f.ftype == 2'd2) n_pkts++;
      end
    end else begin
      chk("idle_type", flit_type_o, 2'd1);
      chk("idle_payload", flit_payload_o, 0);
    end
    if (data_valid_i && can_push) data_q.push_back(data_i);
    if (pkt_valid_i && idle) begin
      n_desc++;
      exp_q.push_back('{2'd0, 1'b0,
        32'(pkt_dst_x_i) + (32'(pkt_dst_y_i) << 4) + (32'd1 << 8) + (32'd1 << 12)});
      if (pkt_len_i == 0) exp_q.push_back('{2'd2, 1'b0, 32'd0});
      for (int i = 1; i <= int'(pkt_len_i); i++)
        exp_q.push_back('{(i == int'(pkt_len_i)) ? 2'd2 : 2'd1, 1'b1, 32'd0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    data_valid_i = 1'b1;
    data_i       = w;
    cycle();
    data_valid_i = 1'b0;
  endtask

  task automatic send_desc(input logic [3:0] x, input logic [3:0] y, input logic [7:0] l);
    pkt_valid_i = 1'b1;
    pkt_dst_x_i = x;
    pkt_dst_y_i = y;
    pkt_len_i   = l;
    cycle();
    pkt_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    ack_i = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid_i = 0; pkt_dst_x_i = 0; pkt_dst_y_i = 0; pkt_len_i = 0;
    data_valid_i = 0; data_i = 0; ack_i = 0;
    #12;
    // Reset values
    chk("rst_enable", enable_o, 0);
    chk("rst_type", flit_type_o, 2'd1);
    chk("rst_payload", flit_payload_o, 0);
    chk("rst_pkt_ready", pkt_ready_o, 1);
    chk("rst_data_ready", data_ready_o, 1);
    chk("rst_flits", flits_sent_o, 0);
    chk("rst_pkts", pkts_sent_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic packet, back-to-back flits
    push_word(32'hA); push_word(32'hB); push_word(32'hC);
    ack_i = 1'b1;
    send_desc(4'd2, 4'd1, 8'd3);
    chk("hdr_type", flit_type_o, 2'd0);
    chk("hdr_payload", flit_payload_o, 32'h1112);
    repeat (4) cycle();
    chk("t2_flits", flits_sent_o, 4);
    chk("t2_pkts", pkts_sent_o, 1);
    chk("t2_busy", busy_o, 0);

    // Router stalls the header for five cycles
    push_word(32'h77);
    ack_i = 1'b0;
    send_desc(4'd5, 4'd6, 8'd1);
    repeat (5) begin
      cycle();
      chk("stall_type", flit_type_o, 2'd0);
      chk("stall_payload", flit_payload_o, 32'h1165);
      chk("stall_flits", flits_sent_o, 4);
    end
    drain(20);

    // Payload arrives late, leaving bubbles
    push_word(32'hA);
    ack_i = 1'b1;
    send_desc(4'd3, 4'd3, 8'd3);
    cycle(); cycle();
    repeat (3) begin
      cycle();
      chk("gap_enable", enable_o, 0);
    end
    push_word(32'hB);
    cycle();
    chk("gap2_enable", enable_o, 0);
    push_word(32'hC);
    chk("tail_on_c", flit_type_o, 2'd2);
    drain(20);

    // Zero-length packet leaves buffered payload alone
    push_word(32'h55);
    send_desc(4'd0, 4'd3, 8'd0);
    chk("len0_hdr", flit_payload_o, 32'h1130);
    cycle();
    chk("len0_tail_type", flit_type_o, 2'd2);
    chk("len0_tail_payload", flit_payload_o, 0);
    drain(20);
    send_desc(4'd1, 4'd1, 8'd1);
    cycle();
    chk("kept_word", flit_payload_o, 32'h55);
    chk("kept_type", flit_type_o, 2'd2);
    drain(20);

    // Fill the FIFO, then reset in the middle of a packet
    for (int i = 0; i < DEPTH; i++) push_word(32'h100 + 32'(i));
    chk("full_ready", data_ready_o, 0);
    send_desc(4'd7, 4'd2, 8'd8);
    cycle(); cycle();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enable", enable_o, 0);
    chk("mid_rst_type", flit_type_o, 2'd1);
    chk("mid_rst_payload", flit_payload_o, 0);
    chk("mid_rst_pkt_ready", pkt_ready_o, 1);
    chk("mid_rst_data_ready", data_ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_flits", flits_sent_o, 0);
    chk("mid_rst_pkts", pkts_sent_o, 0);
    exp_q.delete();
    data_q.delete();
    n_flits = 0;
    n_pkts  = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cycle();

    // Random traffic against the flit-list model
    begin
      int budget = 0;
      int target = n_desc + 40;
      while ((n_desc < target || exp_q.size() != 0) && budget < 20000) begin
        ack_i        = ($urandom_range(0, 9) < 7);
        data_valid_i = ($urandom_range(0, 1) == 1);
        data_i       = $urandom;
        pkt_valid_i  = (n_desc < target) && ($urandom_range(0, 3) != 0);
        pkt_dst_x_i  = 4'($urandom);
        pkt_dst_y_i  = 4'($urandom);
        pkt_len_i    = 8'($urandom_range(0, 20));
        cycle();
        budget++;
      end
      pkt_valid_i  = 1'b0;
      data_valid_i = 1'b0;
      chk("random_done", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/noc_packet_tx.md
Name: noc_packet_tx

Overview:
Network-interface transmitter that sits at the injection end of a router input port.
- Accepts a packet descriptor (destination, length) plus a stream of payload words.
- Serialises them into HEADER / BODY / TAIL flits on the router's enable/ack wormhole handshake.
- Buffers payload in an internal FIFO, holds each flit stable until the router acks it, and counts flits and packets sent.

Parameters:
ADDR_W, 4, width of each X/Y coordinate
PAYLOAD_W, 32, flit payload width; must be >= 4*ADDR_W
LEN_W, 8, width of packet length (payload words)
FIFO_DEPTH, 8, payload FIFO depth (power of 2, >= 2)
CNT_W, 16, statistics counter width
SRC_X, 1, this node's X coordinate, placed in the header
SRC_Y, 1, this node's Y coordinate, placed in the header

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pkt_valid_i  in  1  descriptor valid
pkt_ready_o  out  1  descriptor accepted when valid&&ready
pkt_dst_x_i  in  ADDR_W  destination X
pkt_dst_y_i  in  ADDR_W  destination Y
pkt_len_i  in  LEN_W  payload word count (0 allowed)
data_valid_i  in  1  payload word valid
data_ready_o  out  1  FIFO not full
data_i  in  PAYLOAD_W  payload word
enable_o  out  1  flit valid toward router
flit_type_o  out  2  HEADER=2'd0, BODY=2'd1, TAIL=2'd2 (noc_types encoding)
flit_payload_o  out  PAYLOAD_W  flit payload
ack_i  in  1  router accept/backpressure
busy_o  out  1  state != IDLE
flits_sent_o  out  CNT_W  accepted flit count, wraps
pkts_sent_o  out  CNT_W  accepted TAIL count, wraps

Behaviour:
Reset:
- Async; state IDLE, FIFO empty, counters 0.
- Outputs: enable_o=0, flit_type_o=BODY, flit_payload_o=0, pkt_ready_o=1, data_ready_o=1, busy_o=0.
- Reset mid-packet abandons the packet and flushes the FIFO; outputs return to reset values immediately.

Transfer and output rules:
- A flit transfers at a posedge where enable_o && ack_i.
- All outputs derive from registered state/FIFO head only; there is no combinational path from ack_i, pkt_valid_i or data_valid_i to any output.
- While enable_o && !ack_i, flit_type_o and flit_payload_o hold stable.
- While enable_o=0, flit_type_o=BODY and flit_payload_o=0. HEADER or TAIL is never presented without enable_o.

FIFO:
- data_ready_o = !full. Push on data_valid_i && data_ready_o, in any state.
- Pop only on a BODY/TAIL transfer.
- Simultaneous push and pop adjusts occupancy by 0.

Header payload:
- [ADDR_W-1:0] dst_x
- [2A-1:A] dst_y
- [3A-1:2A] SRC_X
- [4A-1:3A] SRC_Y
- upper bits 0

FSM:
- IDLE: pkt_ready_o=1. On pkt_valid_i, latch dst and len, then go to HDR; the header is presented the next cycle.
- HDR: enable_o=1, type HEADER. On ack_i: rem<=len; go to DATA if len!=0, else EMPTY_TAIL.
- DATA:
  - FIFO non-empty: enable_o=1, payload=FIFO head, type=TAIL if rem==1 else BODY. On ack_i: pop, rem--. If rem was 1, count the packet and go to IDLE.
  - FIFO empty: bubble, enable_o=0.
- EMPTY_TAIL: enable_o=1, TAIL, payload 0. On ack_i go to IDLE.

Throughput and limits:
- Minimum tail-accept to next header: 2 cycles.
- With ack_i held high and the FIFO non-empty, one flit per cycle.
- Packets longer than FIFO_DEPTH stream through the FIFO.
- pkt_ready_o=0 in every non-IDLE state.
- Counters wrap modulo 2^CNT_W.

Test Plan:
1. Reset -> enable_o=0, flit_type_o=1, payload 0, pkt_ready_o=1, data_ready_o=1, counters 0.
2. Preload 0xA,0xB,0xC; descriptor dst(2,1) len 3; ack_i=1 -> consecutive flits HEADER payload 0x1112, BODY 0xA, BODY 0xB, TAIL 0xC; flits_sent_o=4, pkts_sent_o=1, busy_o falls after TAIL.
3. ack_i=0 for 5 cycles during HDR -> HEADER held stable 6 cycles, pkt_ready_o=0, flits_sent_o unchanged until ack.
4. len 3, only 0xA in FIFO; 0xB pushed 4 cycles later, 0xC 2 cycles after that -> enable_o=0 with BODY/0 during gaps, TAIL only on 0xC.
5. len 0, dst(0,3) -> HEADER then TAIL payload 0; FIFO contents untouched.
6. Push FIFO_DEPTH words with no descriptor -> data_ready_o=0 after 8th push. Then start len 8 and assert rst mid-packet -> outputs return to reset values without a clock edge and the FIFO is empty.
